// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response-compaction stage: state encoding
// and the default MISR constants for an 8-bit response bus.
package bist_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPACT = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    COMPACT = ST_COMPACT,
    COMPARE = ST_COMPARE,
    DONE_ST = ST_DONE
  } state_t;

  // x^8 + x^4 + x^3 + x^2 + 1
  localparam logic [7:0] DEF_POLY   = 8'h1D;
  localparam logic [7:0] DEF_SEED   = 8'h00;
  localparam logic [7:0] DEF_GOLDEN = 8'h00;

endpackage

// File: rtl/misr_reg.sv
// W-bit multiple-input signature register. load (reseed) has priority over
// en (compact one response word).
module misr_reg #(
  parameter int          W    = 8,
  parameter logic [W-1:0] POLY = W'(8'h1D),
  parameter logic [W-1:0] SEED = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  logic [W-1:0] feedback;

  assign feedback = sig[W-1] ? POLY : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= {sig[W-2:0], 1'b0} ^ feedback ^ din;
    end
  end

endmodule

// File: rtl/bist_misr_checker.sv
// Compacts CUT responses into a MISR, counts captures and latches a PASS/FAIL
// verdict against golden signature and count once the controller signals FINISH.
module bist_misr_checker
  import bist_pkg::*;
#(
  parameter int           W       = 8,
  parameter logic [W-1:0] POLY    = W'(DEF_POLY),
  parameter logic [W-1:0] SEED    = W'(DEF_SEED),
  parameter logic [W-1:0] GOLDEN  = W'(DEF_GOLDEN),
  parameter int           CW      = 16,
  parameter logic [CW-1:0] EXP_CNT = CW'(81)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          INIT,
  input  logic          OUT_VALID,
  input  logic          FINISH,
  input  logic [W-1:0]  CUT_RESP,
  output logic [W-1:0]  SIGNATURE,
  output logic [CW-1:0] CAP_CNT,
  output logic          DONE,
  output logic          PASS,
  output logic          FAIL,
  output logic          ERR_SEQ
);

  // Handshake: the controller strobes are single-cycle qualifiers sampled on
  // each rising CLK edge; there is no backpressure. A response word is taken
  // exactly when OUT_VALID is high in COMPACT and INIT is low, and INIT
  // overrides every other strobe in every state.

  state_t state;
  logic   cap_en;
  logic   pass_now;
  logic   proto_err;

  assign cap_en    = (state == COMPACT) && OUT_VALID && !INIT;
  assign pass_now  = (SIGNATURE == GOLDEN) && (CAP_CNT == EXP_CNT);
  assign proto_err = OUT_VALID || FINISH;

  misr_reg #(
    .W    (W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk   (CLK),
    .reset (RESET),
    .load  (INIT),
    .en    (cap_en),
    .din   (CUT_RESP),
    .sig   (SIGNATURE)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      CAP_CNT <= '0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
      FAIL    <= 1'b0;
      ERR_SEQ <= 1'b0;
    end else if (INIT) begin
      state   <= COMPACT;
      CAP_CNT <= '0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
      FAIL    <= 1'b0;
      ERR_SEQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (proto_err) ERR_SEQ <= 1'b1;
        end
        COMPACT: begin
          if (OUT_VALID && (CAP_CNT != '1)) CAP_CNT <= CAP_CNT + CW'(1);
          if (FINISH) state <= COMPARE;
        end
        // SIGNATURE and CAP_CNT already include a capture made alongside FINISH.
        COMPARE: begin
          DONE  <= 1'b1;
          PASS  <= pass_now;
          FAIL  <= !pass_now;
          state <= DONE_ST;
          if (proto_err) ERR_SEQ <= 1'b1;
        end
        DONE_ST: begin
          if (proto_err) ERR_SEQ <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_misr_checker.sv
// Directed bench for bist_misr_checker: a per-cycle vector table plus
// hand-written full sessions for the pass/fail and simultaneity corners.
module tb_bist_misr_checker;

  logic        CLK;
  logic        RESET;
  logic        INIT;
  logic        OUT_VALID;
  logic        FINISH;
  logic [7:0]  CUT_RESP;
  logic [7:0]  SIGNATURE;
  logic [15:0] CAP_CNT;
  logic        DONE, PASS, FAIL, ERR_SEQ;
  logic [7:0]  sig2;
  logic [15:0] cnt2;
  logic        done2, pass2, fail2, err2;

  int n_checks = 0;
  int n_fail   = 0;

  bist_misr_checker dut (
    .CLK (CLK), .RESET (RESET), .INIT (INIT), .OUT_VALID (OUT_VALID),
    .FINISH (FINISH), .CUT_RESP (CUT_RESP), .SIGNATURE (SIGNATURE),
    .CAP_CNT (CAP_CNT), .DONE (DONE), .PASS (PASS), .FAIL (FAIL),
    .ERR_SEQ (ERR_SEQ)
  );

  bist_misr_checker #(.SEED (8'h80)) dut_seed (
    .CLK (CLK), .RESET (RESET), .INIT (INIT), .OUT_VALID (OUT_VALID),
    .FINISH (FINISH), .CUT_RESP (CUT_RESP), .SIGNATURE (sig2),
    .CAP_CNT (cnt2), .DONE (done2), .PASS (pass2), .FAIL (fail2),
    .ERR_SEQ (err2)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        init, ov, fin;
    logic [7:0]  resp;
    logic [7:0]  sig, sig2;
    logic [15:0] cnt;
    logic        done, pass, fail, err;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    INIT = 1'b0; OUT_VALID = 1'b0; FINISH = 1'b0; CUT_RESP = 8'h00;
    step();
    step();
    RESET = 1'b0;
    step();
  endtask

  task automatic start();
    INIT = 1'b1;
    step();
    INIT = 1'b0;
  endtask

  task automatic capture(input logic [7:0] r);
    OUT_VALID = 1'b1;
    CUT_RESP  = r;
    step();
    OUT_VALID = 1'b0;
    CUT_RESP  = 8'h00;
    repeat ($urandom_range(0, 2)) step();
  endtask

  // Drives FINISH (optionally with a final capture) and checks the verdict
  // appears exactly on the second edge.
  task automatic finish_check(input string name, input logic with_ov,
                              input logic exp_pass, input logic [15:0] exp_cnt);
    FINISH    = 1'b1;
    OUT_VALID = with_ov;
    CUT_RESP  = 8'h00;
    step();
    FINISH    = 1'b0;
    OUT_VALID = 1'b0;
    check({name, " done_early"}, {31'd0, DONE}, 32'd0);
    step();
    check({name, " done"}, {31'd0, DONE}, 32'd1);
    check({name, " pass"}, {31'd0, PASS}, {31'd0, exp_pass});
    check({name, " fail"}, {31'd0, FAIL}, {31'd0, !exp_pass});
    check({name, " cnt"},  {16'd0, CAP_CNT}, {16'd0, exp_cnt});
    check({name, " state"}, {30'd0, dut.state}, 32'd3);
  endtask

  initial begin
    //          init ov fin resp   sig    sig2   cnt  done pass fail err st
    tbl[0]  = '{1'b0,1'b1,1'b0,8'h00, 8'h00,8'h80,16'd0,1'b0,1'b0,1'b0,1'b1,2'd0};
    tbl[1]  = '{1'b1,1'b0,1'b0,8'h00, 8'h00,8'h80,16'd0,1'b0,1'b0,1'b0,1'b0,2'd1};
    tbl[2]  = '{1'b0,1'b1,1'b0,8'h01, 8'h01,8'h1C,16'd1,1'b0,1'b0,1'b0,1'b0,2'd1};
    tbl[3]  = '{1'b0,1'b0,1'b0,8'hFF, 8'h01,8'h1C,16'd1,1'b0,1'b0,1'b0,1'b0,2'd1};
    tbl[4]  = '{1'b0,1'b1,1'b0,8'h00, 8'h02,8'h38,16'd2,1'b0,1'b0,1'b0,1'b0,2'd1};
    tbl[5]  = '{1'b0,1'b1,1'b0,8'h80, 8'h84,8'hF0,16'd3,1'b0,1'b0,1'b0,1'b0,2'd1};
    tbl[6]  = '{1'b0,1'b1,1'b0,8'h00, 8'h15,8'hFD,16'd4,1'b0,1'b0,1'b0,1'b0,2'd1};
    tbl[7]  = '{1'b0,1'b0,1'b1,8'h00, 8'h15,8'hFD,16'd4,1'b0,1'b0,1'b0,1'b0,2'd2};
    tbl[8]  = '{1'b0,1'b0,1'b0,8'h00, 8'h15,8'hFD,16'd4,1'b1,1'b0,1'b1,1'b0,2'd3};
    tbl[9]  = '{1'b0,1'b1,1'b0,8'h00, 8'h15,8'hFD,16'd4,1'b1,1'b0,1'b1,1'b1,2'd3};
    tbl[10] = '{1'b1,1'b1,1'b0,8'h00, 8'h00,8'h80,16'd0,1'b0,1'b0,1'b0,1'b0,2'd1};
    tbl[11] = '{1'b0,1'b1,1'b0,8'h00, 8'h00,8'h1D,16'd1,1'b0,1'b0,1'b0,1'b0,2'd1};
    tbl[12] = '{1'b1,1'b0,1'b1,8'h00, 8'h00,8'h80,16'd0,1'b0,1'b0,1'b0,1'b0,2'd1};
    tbl[13] = '{1'b0,1'b1,1'b1,8'h00, 8'h00,8'h1D,16'd1,1'b0,1'b0,1'b0,1'b0,2'd2};
    tbl[14] = '{1'b0,1'b1,1'b0,8'h00, 8'h00,8'h1D,16'd1,1'b1,1'b0,1'b1,1'b1,2'd3};

    do_reset();
    check("reset sig",   {24'd0, SIGNATURE}, 32'h00);
    check("reset sig2",  {24'd0, sig2}, 32'h80);
    check("reset cnt",   {16'd0, CAP_CNT}, 32'd0);
    check("reset flags", {28'd0, DONE, PASS, FAIL, ERR_SEQ}, 32'd0);
    check("reset state", {30'd0, dut.state}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      INIT = tbl[i].init; OUT_VALID = tbl[i].ov; FINISH = tbl[i].fin;
      CUT_RESP = tbl[i].resp;
      step();
      check($sformatf("vec%0d sig", i),   {24'd0, SIGNATURE}, {24'd0, tbl[i].sig});
      check($sformatf("vec%0d sig2", i),  {24'd0, sig2},      {24'd0, tbl[i].sig2});
      check($sformatf("vec%0d cnt", i),   {16'd0, CAP_CNT},   {16'd0, tbl[i].cnt});
      check($sformatf("vec%0d done", i),  {31'd0, DONE},      {31'd0, tbl[i].done});
      check($sformatf("vec%0d pass", i),  {31'd0, PASS},      {31'd0, tbl[i].pass});
      check($sformatf("vec%0d fail", i),  {31'd0, FAIL},      {31'd0, tbl[i].fail});
      check($sformatf("vec%0d err", i),   {31'd0, ERR_SEQ},   {31'd0, tbl[i].err});
      check($sformatf("vec%0d state", i), {30'd0, dut.state}, {30'd0, tbl[i].st});
    end
    INIT = 1'b0; OUT_VALID = 1'b0; FINISH = 1'b0; CUT_RESP = 8'h00;

    // pass path, then INIT in DONE_ST clears the verdict
    do_reset();
    start();
    for (int i = 0; i < 81; i++) capture(8'h00);
    finish_check("pass", 1'b0, 1'b1, 16'd81);
    check("pass err", {31'd0, ERR_SEQ}, 32'd0);
    start();
    check("reinit flags", {29'd0, DONE, PASS, FAIL}, 32'd0);
    check("reinit state", {30'd0, dut.state}, 32'd1);

    // corrupted response
    start();
    for (int i = 0; i < 81; i++) capture((i == 40) ? 8'h04 : 8'h00);
    finish_check("bad_resp", 1'b0, 1'b0, 16'd81);

    // count short by one
    start();
    for (int i = 0; i < 80; i++) capture(8'h00);
    finish_check("short_cnt", 1'b0, 1'b0, 16'd80);

    // 81st vector arrives with FINISH
    start();
    for (int i = 0; i < 80; i++) capture(8'h00);
    finish_check("ov_fin", 1'b1, 1'b1, 16'd81);

    // asynchronous reset in the middle of a session
    start();
    capture(8'h5A);
    capture(8'h33);
    #3 RESET = 1'b1;
    #1;
    check("async sig", {24'd0, SIGNATURE}, 32'h00);
    check("async cnt", {16'd0, CAP_CNT}, 32'd0);
    step();
    check("rst state", {30'd0, dut.state}, 32'd0);
    check("rst done",  {31'd0, DONE}, 32'd0);
    RESET = 1'b0;
    step();
    check("post_rst state", {30'd0, dut.state}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
